// File: rtl/openddr_pkg.sv
// OpenDDR shared package: DFI defaults and data-path entry types.
// Entry typedefs are sized for the default 4-phase, 64-bit DFI configuration.
package openddr_pkg;

    localparam int DFI_DATA_WIDTH_DEFAULT = 64;
    localparam int DFI_NUM_PHASES_DEFAULT = 4;
    localparam int DFI_WRLAT_MAX_DEFAULT  = 15;
    localparam int DFI_MAX_BURST_DEFAULT  = 4;
    localparam int DFI_FIFO_DEPTH_DEFAULT = 8;

    localparam int DFI_BUS_W  = DFI_DATA_WIDTH_DEFAULT * DFI_NUM_PHASES_DEFAULT;
    localparam int DFI_MASK_W = DFI_BUS_W / 8;

    typedef struct packed {
        logic [DFI_BUS_W-1:0]  data;
        logic [DFI_MASK_W-1:0] mask;
    } dfi_wr_entry_t;

    typedef struct packed {
        logic [DFI_BUS_W-1:0]              data;
        logic [DFI_NUM_PHASES_DEFAULT-1:0] phase_valid;
    } dfi_rd_entry_t;

endpackage

// File: rtl/openddr_sync_fifo.sv
// OpenDDR synchronous first-word-fall-through FIFO.
// Pointers carry one extra wrap bit; full/empty come from the MSB compare.
module openddr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) &&
                      (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count    = wptr - rptr;
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rptr[AW-1:0]];

    // Pointer update; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; a push into a full FIFO reuses the slot being popped.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/openddr_dfi_phase_datapath.sv
// OpenDDR DFI phase data path: latency-scheduled write launch and
// read capture FIFO with sticky underrun/collision/overflow flags.
module openddr_dfi_phase_datapath
    import openddr_pkg::*;
#(
    parameter int DATA_WIDTH    = DFI_DATA_WIDTH_DEFAULT,
    parameter int NUM_PHASES    = DFI_NUM_PHASES_DEFAULT,
    parameter int WRLAT_MAX     = DFI_WRLAT_MAX_DEFAULT,
    parameter int MAX_BURST     = DFI_MAX_BURST_DEFAULT,
    parameter int WR_FIFO_DEPTH = DFI_FIFO_DEPTH_DEFAULT,
    parameter int RD_FIFO_DEPTH = DFI_FIFO_DEPTH_DEFAULT,
    localparam int BW  = NUM_PHASES * DATA_WIDTH,
    localparam int MW  = BW / 8,
    localparam int LW  = $clog2(WRLAT_MAX + 1),
    localparam int BLW = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LW-1:0]         cfg_wrlat,
    input  logic                  wr_cmd_valid,
    input  logic [BLW-1:0]        wr_cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [BW-1:0]         wdata,
    input  logic [MW-1:0]         wstrb,
    output logic [BW-1:0]         dfi_wrdata,
    output logic [MW-1:0]         dfi_wrdata_mask,
    output logic [NUM_PHASES-1:0] dfi_wrdata_en,
    input  logic [BW-1:0]         dfi_rddata,
    input  logic [NUM_PHASES-1:0] dfi_rddata_valid,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [BW-1:0]         rd_data,
    output logic [NUM_PHASES-1:0] rd_phase_valid,
    input  logic                  err_clr,
    output logic                  err_wr_underrun,
    output logic                  err_wr_collision,
    output logic                  err_rd_overflow
);

    localparam int SW = WRLAT_MAX + MAX_BURST;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [MW-1:0] mask;
    } wr_entry_t;

    typedef struct packed {
        logic [BW-1:0]         data;
        logic [NUM_PHASES-1:0] phase_valid;
    } rd_entry_t;

    wr_entry_t wr_in;
    wr_entry_t wr_head;
    rd_entry_t rd_in;
    rd_entry_t rd_head;

    logic wr_full, wr_empty, wr_push, wr_pop;
    logic rd_full, rd_empty, rd_push, rd_pop;
    logic [$clog2(WR_FIFO_DEPTH):0] wr_count;
    logic [$clog2(RD_FIFO_DEPTH):0] rd_count;
    logic unused_cnt;

    logic           ready_en;
    logic [SW-1:0]  sched_q;
    logic [SW-1:0]  sched_sh;
    logic [SW-1:0]  sched_mask;
    logic [SW-1:0]  sched_d;
    logic [BLW-1:0] len_c;
    logic           collision;
    logic           launch;
    logic           underrun_q;
    logic           rd_capture;
    logic           overflow;

    assign unused_cnt = ^{wr_count, rd_count};

    // ---------------- write side ----------------
    assign wdata_ready = ready_en & ~wr_full;
    assign wr_push     = wdata_valid & wdata_ready;
    assign wr_in.data  = wdata;
    assign wr_in.mask  = ~wstrb;

    openddr_sync_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (WR_FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_push),
        .push_data (wr_in),
        .pop       (wr_pop),
        .pop_data  (wr_head),
        .full      (wr_full),
        .empty     (wr_empty),
        .count     (wr_count)
    );

    // Next schedule: shift, then OR in the clamped burst window.
    always_comb begin
        len_c      = (wr_cmd_len > BLW'(MAX_BURST)) ?
                     BLW'(MAX_BURST) : wr_cmd_len;
        sched_sh   = sched_q >> 1;
        sched_mask = '0;
        if (wr_cmd_valid)
            sched_mask = ((SW'(1) << len_c) - SW'(1)) << cfg_wrlat;
        collision  = |(sched_sh & sched_mask);
        sched_d    = sched_sh | sched_mask;
    end

    assign launch = sched_d[0];
    assign wr_pop = launch & ~wr_empty;

    // Schedule register and write-ready enable after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sched_q  <= '0;
            ready_en <= 1'b0;
        end else begin
            sched_q  <= sched_d;
            ready_en <= 1'b1;
        end
    end

    // Registered DFI write outputs; empty FIFO at launch drives zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dfi_wrdata      <= '0;
            dfi_wrdata_mask <= '1;
            dfi_wrdata_en   <= '0;
            underrun_q      <= 1'b0;
        end else begin
            dfi_wrdata_en <= {NUM_PHASES{launch}};
            underrun_q    <= launch & wr_empty;
            if (launch) begin
                dfi_wrdata      <= wr_empty ? '0 : wr_head.data;
                dfi_wrdata_mask <= wr_empty ? '1 : wr_head.mask;
            end else begin
                dfi_wrdata_mask <= '1;
            end
        end
    end

    // ---------------- read side ----------------
    // Capture entry with invalid phase lanes forced to zero.
    always_comb begin
        rd_in.data        = '0;
        rd_in.phase_valid = dfi_rddata_valid;
        for (int p = 0; p < NUM_PHASES; p++) begin
            if (dfi_rddata_valid[p])
                rd_in.data[p*DATA_WIDTH +: DATA_WIDTH] =
                    dfi_rddata[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign rd_capture = |dfi_rddata_valid;
    assign rd_valid   = ~rd_empty;
    assign rd_pop     = rd_valid & rd_ready;
    assign rd_push    = rd_capture & (~rd_full | rd_pop);
    assign overflow   = rd_capture & rd_full & ~rd_pop;

    openddr_sync_fifo #(
        .WIDTH ($bits(rd_entry_t)),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_push),
        .push_data (rd_in),
        .pop       (rd_pop),
        .pop_data  (rd_head),
        .full      (rd_full),
        .empty     (rd_empty),
        .count     (rd_count)
    );

    assign rd_data        = rd_empty ? '0 : rd_head.data;
    assign rd_phase_valid = rd_empty ? '0 : rd_head.phase_valid;

    // Sticky error flags; a new event wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_wr_underrun  <= 1'b0;
            err_wr_collision <= 1'b0;
            err_rd_overflow  <= 1'b0;
        end else begin
            err_wr_underrun  <= underrun_q | (err_wr_underrun & ~err_clr);
            err_wr_collision <= collision | (err_wr_collision & ~err_clr);
            err_rd_overflow  <= overflow | (err_rd_overflow & ~err_clr);
        end
    end

endmodule

// File: tb/tb_openddr_dfi_phase_datapath.sv
// Directed self-checking bench for openddr_dfi_phase_datapath.
// Default parameters: 4 phases x 64 bits, WRLAT_MAX 15, bursts up to 4.
module tb_openddr_dfi_phase_datapath;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   cfg_wrlat;
    logic         wr_cmd_valid;
    logic [2:0]   wr_cmd_len;
    logic         wdata_valid;
    logic         wdata_ready;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic [255:0] dfi_wrdata;
    logic [31:0]  dfi_wrdata_mask;
    logic [3:0]   dfi_wrdata_en;
    logic [255:0] dfi_rddata;
    logic [3:0]   dfi_rddata_valid;
    logic         rd_valid;
    logic         rd_ready;
    logic [255:0] rd_data;
    logic [3:0]   rd_phase_valid;
    logic         err_clr;
    logic         err_wr_underrun;
    logic         err_wr_collision;
    logic         err_rd_overflow;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] B0 = {64'h1111_0003, 64'h1111_0002,
                                   64'h1111_0001, 64'h1111_0000};
    localparam logic [255:0] B1 = {4{64'h2222_3333_4444_5555}};

    openddr_dfi_phase_datapath dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_wrlat        (cfg_wrlat),
        .wr_cmd_valid     (wr_cmd_valid),
        .wr_cmd_len       (wr_cmd_len),
        .wdata_valid      (wdata_valid),
        .wdata_ready      (wdata_ready),
        .wdata            (wdata),
        .wstrb            (wstrb),
        .dfi_wrdata       (dfi_wrdata),
        .dfi_wrdata_mask  (dfi_wrdata_mask),
        .dfi_wrdata_en    (dfi_wrdata_en),
        .dfi_rddata       (dfi_rddata),
        .dfi_rddata_valid (dfi_rddata_valid),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_data          (rd_data),
        .rd_phase_valid   (rd_phase_valid),
        .err_clr          (err_clr),
        .err_wr_underrun  (err_wr_underrun),
        .err_wr_collision (err_wr_collision),
        .err_rd_overflow  (err_rd_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_wrlat = '0; wr_cmd_valid = 0; wr_cmd_len = '0;
        wdata_valid = 0; wdata = '0; wstrb = '0;
        dfi_rddata = '0; dfi_rddata_valid = '0;
        rd_ready = 0; err_clr = 0;
        #20;
        checks++; if (dfi_wrdata_en !== 4'h0) begin errors++;
            $display("FAIL reset_en got %h exp 0", dfi_wrdata_en); end
        checks++; if (dfi_wrdata_mask !== 32'hFFFF_FFFF) begin errors++;
            $display("FAIL reset_mask got %h exp ffffffff", dfi_wrdata_mask); end
        checks++; if (dfi_wrdata !== '0) begin errors++;
            $display("FAIL reset_data got %h exp 0", dfi_wrdata); end
        checks++; if ({rd_valid, rd_phase_valid} !== 5'b0) begin errors++;
            $display("FAIL reset_rd got %b exp 0", {rd_valid, rd_phase_valid}); end
        checks++; if (rd_data !== '0) begin errors++;
            $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        checks++;
        if ({err_wr_underrun, err_wr_collision, err_rd_overflow} !== 3'b0) begin
            errors++;
            $display("FAIL reset_err got %b exp 000",
                     {err_wr_underrun, err_wr_collision, err_rd_overflow});
        end
        rst_n = 1'b1;
        step();
        checks++; if (wdata_ready !== 1'b1) begin errors++;
            $display("FAIL reset_wready got %b exp 1", wdata_ready); end
    endtask

    task automatic test_basic_write();
        logic [3:0] exp_en;
        cfg_wrlat = 4'd3;
        wdata_valid = 1; wdata = B0; wstrb = 32'h0000_00FF;
        step();
        wdata = B1; wstrb = 32'hFFFF_FFFF;
        step();
        wdata_valid = 0;
        wr_cmd_valid = 1; wr_cmd_len = 3'd2;
        step();
        wr_cmd_valid = 0;
        for (int i = 1; i <= 7; i++) begin
            exp_en = (i == 4 || i == 5) ? 4'hF : 4'h0;
            checks++; if (dfi_wrdata_en !== exp_en) begin errors++;
                $display("FAIL wr_en c%0d got %h exp %h", i, dfi_wrdata_en, exp_en); end
            if (i == 4) begin
                checks++; if (dfi_wrdata !== B0) begin errors++;
                    $display("FAIL wr_beat0 got %h exp %h", dfi_wrdata, B0); end
                checks++; if (dfi_wrdata_mask !== 32'hFFFF_FF00) begin errors++;
                    $display("FAIL wr_mask0 got %h exp ffffff00", dfi_wrdata_mask); end
            end
            if (i == 5) begin
                checks++; if (dfi_wrdata !== B1) begin errors++;
                    $display("FAIL wr_beat1 got %h exp %h", dfi_wrdata, B1); end
                checks++; if (dfi_wrdata_mask !== 32'h0) begin errors++;
                    $display("FAIL wr_mask1 got %h exp 0", dfi_wrdata_mask); end
            end
            if (i == 6) begin
                checks++;
                if (dfi_wrdata !== B1 || dfi_wrdata_mask !== 32'hFFFF_FFFF) begin
                    errors++;
                    $display("FAIL wr_idle got %h/%h exp hold/ffffffff",
                             dfi_wrdata, dfi_wrdata_mask);
                end
            end
            step();
        end
        checks++; if (err_wr_underrun !== 1'b0) begin errors++;
            $display("FAIL wr_no_underrun got %b exp 0", err_wr_underrun); end
    endtask

    task automatic test_underrun();
        cfg_wrlat = 4'd0;
        wr_cmd_valid = 1; wr_cmd_len = 3'd1;
        step();
        wr_cmd_valid = 0;
        checks++; if (dfi_wrdata_en !== 4'hF) begin errors++;
            $display("FAIL ur_en got %h exp f", dfi_wrdata_en); end
        checks++;
        if (dfi_wrdata !== '0 || dfi_wrdata_mask !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL ur_data got %h/%h exp 0/ffffffff",
                     dfi_wrdata, dfi_wrdata_mask);
        end
        checks++; if (err_wr_underrun !== 1'b0) begin errors++;
            $display("FAIL ur_err_early got %b exp 0", err_wr_underrun); end
        step();
        checks++; if (err_wr_underrun !== 1'b1) begin errors++;
            $display("FAIL ur_err_set got %b exp 1", err_wr_underrun); end
        step(); step();
        checks++; if (err_wr_underrun !== 1'b1) begin errors++;
            $display("FAIL ur_err_hold got %b exp 1", err_wr_underrun); end
        clear_errors();
        checks++; if (err_wr_underrun !== 1'b0) begin errors++;
            $display("FAIL ur_err_clr got %b exp 0", err_wr_underrun); end
    endtask

    task automatic test_collision();
        logic [3:0] exp_en;
        cfg_wrlat = 4'd2;
        wr_cmd_valid = 1; wr_cmd_len = 3'd4;
        step();
        wr_cmd_len = 3'd2;
        step();
        wr_cmd_valid = 0;
        checks++; if (err_wr_collision !== 1'b1) begin errors++;
            $display("FAIL col_err got %b exp 1", err_wr_collision); end
        for (int c = 2; c <= 8; c++) begin
            exp_en = (c >= 3 && c <= 6) ? 4'hF : 4'h0;
            checks++; if (dfi_wrdata_en !== exp_en) begin errors++;
                $display("FAIL col_en c%0d got %h exp %h", c, dfi_wrdata_en, exp_en); end
            step();
        end
        clear_errors();
        checks++; if (err_wr_collision !== 1'b0) begin errors++;
            $display("FAIL col_clr got %b exp 0", err_wr_collision); end
        // zero length: ignored entirely
        cfg_wrlat = 4'd0;
        wr_cmd_valid = 1; wr_cmd_len = 3'd0;
        step();
        wr_cmd_valid = 0;
        step();
        checks++;
        if (dfi_wrdata_en !== 4'h0 || err_wr_collision !== 1'b0 ||
            err_wr_underrun !== 1'b0) begin
            errors++;
            $display("FAIL len0 got en=%h col=%b ur=%b exp 0/0/0",
                     dfi_wrdata_en, err_wr_collision, err_wr_underrun);
        end
        // oversize length clamps to 4 DFI cycles
        wr_cmd_valid = 1; wr_cmd_len = 3'd7;
        step();
        wr_cmd_valid = 0;
        for (int c = 1; c <= 6; c++) begin
            exp_en = (c <= 4) ? 4'hF : 4'h0;
            checks++; if (dfi_wrdata_en !== exp_en) begin errors++;
                $display("FAIL clamp_en c%0d got %h exp %h", c, dfi_wrdata_en, exp_en); end
            step();
        end
        clear_errors();
    endtask

    task automatic test_read_capture();
        dfi_rddata = {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA};
        dfi_rddata_valid = 4'b0011;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++;
            $display("FAIL rd_early got %b exp 0", rd_valid); end
        step();
        dfi_rddata_valid = 4'b0000;
        checks++; if (rd_valid !== 1'b1 || rd_phase_valid !== 4'b0011) begin
            errors++;
            $display("FAIL rd_cap got %b/%b exp 1/0011", rd_valid, rd_phase_valid);
        end
        checks++;
        if (rd_data !== {128'h0, 64'hBBBB, 64'hAAAA}) begin errors++;
            $display("FAIL rd_lanes got %h", rd_data); end
        rd_ready = 1;
        step();
        rd_ready = 0;
        checks++; if (rd_valid !== 1'b0) begin errors++;
            $display("FAIL rd_pop got %b exp 0", rd_valid); end
    endtask

    task automatic test_rd_overflow();
        rd_ready = 0;
        for (int i = 0; i < 9; i++) begin
            dfi_rddata = {4{64'(i + 1)}};
            dfi_rddata_valid = 4'hF;
            step();
        end
        dfi_rddata_valid = 4'h0;
        checks++; if (err_rd_overflow !== 1'b1) begin errors++;
            $display("FAIL ov_err got %b exp 1", err_rd_overflow); end
        checks++; if (rd_valid !== 1'b1 || rd_data !== {4{64'd1}}) begin
            errors++;
            $display("FAIL ov_head got %b/%h exp 1/1", rd_valid, rd_data);
        end
        clear_errors();
        checks++; if (err_rd_overflow !== 1'b0) begin errors++;
            $display("FAIL ov_clr got %b exp 0", err_rd_overflow); end
        rd_ready = 1;
        dfi_rddata = {4{64'h99}};
        dfi_rddata_valid = 4'hF;
        step();
        dfi_rddata_valid = 4'h0;
        rd_ready = 0;
        step();
        checks++; if (err_rd_overflow !== 1'b0) begin errors++;
            $display("FAIL ov_pushpop got %b exp 0", err_rd_overflow); end
        rd_ready = 1;
        for (int j = 2; j <= 8; j++) begin
            checks++; if (rd_valid !== 1'b1 || rd_data !== {4{64'(j)}}) begin
                errors++;
                $display("FAIL ov_drain%0d got %b/%h", j, rd_valid, rd_data);
            end
            step();
        end
        checks++; if (rd_valid !== 1'b1 || rd_data !== {4{64'h99}}) begin
            errors++;
            $display("FAIL ov_last got %b/%h exp 1/99", rd_valid, rd_data);
        end
        step();
        rd_ready = 0;
        checks++; if (rd_valid !== 1'b0) begin errors++;
            $display("FAIL ov_empty got %b exp 0", rd_valid); end
    endtask

    task automatic test_reset_mid_burst();
        wdata_valid = 1; wstrb = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            wdata = {4{64'hC0 + 64'(i)}};
            step();
        end
        wdata_valid = 0;
        dfi_rddata = {4{64'h77}};
        dfi_rddata_valid = 4'hF;
        step();
        dfi_rddata_valid = 4'h0;
        cfg_wrlat = 4'd0;
        wr_cmd_valid = 1; wr_cmd_len = 3'd4;
        step();
        wr_cmd_valid = 0;
        checks++; if (dfi_wrdata_en !== 4'hF) begin errors++;
            $display("FAIL mid_en_pre got %h exp f", dfi_wrdata_en); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dfi_wrdata_en !== 4'h0 || dfi_wrdata_mask !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mid_async got %h/%h exp 0/ffffffff",
                     dfi_wrdata_en, dfi_wrdata_mask);
        end
        checks++; if (rd_valid !== 1'b0) begin errors++;
            $display("FAIL mid_rd_empty got %b exp 0", rd_valid); end
        #1;
        rst_n = 1'b1;
        step();
        checks++; if (wdata_ready !== 1'b1) begin errors++;
            $display("FAIL mid_wready got %b exp 1", wdata_ready); end
        for (int c = 0; c < 6; c++) begin
            checks++; if (dfi_wrdata_en !== 4'h0) begin errors++;
                $display("FAIL mid_en_post c%0d got %h exp 0", c, dfi_wrdata_en); end
            step();
        end
        wr_cmd_valid = 1; wr_cmd_len = 3'd1;
        step();
        wr_cmd_valid = 0;
        checks++; if (dfi_wrdata_en !== 4'hF || dfi_wrdata !== '0) begin
            errors++;
            $display("FAIL mid_wr_empty got %h/%h exp f/0", dfi_wrdata_en, dfi_wrdata);
        end
        step();
        checks++; if (err_wr_underrun !== 1'b1) begin errors++;
            $display("FAIL mid_underrun got %b exp 1", err_wr_underrun); end
        clear_errors();
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_underrun();
        test_collision();
        test_read_capture();
        test_rd_overflow();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
